// File: rtl/booth_pkg.sv
// Shared types and constants for the Booth multiply-accumulate stage.
package booth_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 11;
    localparam int CNT_W_DEF  = 4;

    localparam logic signed [ACC_W_DEF-1:0] ACC_MAX = {1'b0, {(ACC_W_DEF-1){1'b1}}};
    localparam logic signed [ACC_W_DEF-1:0] ACC_MIN = {1'b1, {(ACC_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } mac_state_e;

endpackage

// File: rtl/booth_sat_add.sv
// Sign-extends a product, adds it to the accumulator one bit wider, and clamps
// the result to the signed accumulator range.
module booth_sat_add #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 11
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sat_o
);

    localparam int SUM_W = ACC_W + 1;

    logic [SUM_W-1:0] acc_ext;
    logic [SUM_W-1:0] prod_ext;
    logic [SUM_W-1:0] sum_wide;

    always_comb begin
        acc_ext  = {acc_i[ACC_W-1], acc_i};
        prod_ext = {{(SUM_W-PROD_W){prod_i[PROD_W-1]}}, prod_i};
        sum_wide = acc_ext + prod_ext;
        // The wide sum cannot itself overflow, so a mismatch of its top two
        // bits means the result left the accumulator range; the MSB gives the side.
        sat_o = sum_wide[SUM_W-1] ^ sum_wide[SUM_W-2];
        if (!sat_o) begin
            sum_o = sum_wide[ACC_W-1:0];
        end else if (sum_wide[SUM_W-1]) begin
            sum_o = {1'b1, {(ACC_W-1){1'b0}}};
        end else begin
            sum_o = {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/booth_mac_accumulator.sv
// Block accumulator behind the 4x4 Booth multiplier: sums N products with
// saturation and holds the result until the consumer acknowledges it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no block active, acc_o keeps the last result
// ST_ACCUM | accepting products, one per cycle when valid
// ST_DONE  | block result on acc_o, waiting for res_ready_i or start_i
module booth_mac_accumulator
    import booth_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  len_i,
    input  logic [PROD_W-1:0] prod_i,
    input  logic              prod_valid_i,
    output logic              prod_ready_o,
    input  logic              res_ready_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic              done_o,
    output logic              sat_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  cnt_o
);

    mac_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_sat;

    booth_sat_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_add (
        .acc_i  (acc_q),
        .prod_i (prod_i),
        .sum_o  (add_sum),
        .sat_o  (add_sat)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        if (ena) begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        sat_d   = 1'b0;
                        cnt_d   = '0;
                        len_d   = len_i;
                    end
                end
                ST_ACCUM: begin
                    if (prod_valid_i) begin
                        acc_d = add_sum;
                        sat_d = sat_q | add_sat;
                        cnt_d = cnt_q + CNT_W'(1);
                        // len 0 stands for a full 2^CNT_W block; len-1 wraps to all ones.
                        if (cnt_q == len_q - CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (start_i) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        sat_d   = 1'b0;
                        cnt_d   = '0;
                        len_d   = len_i;
                    end else if (res_ready_i) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign acc_o        = acc_q;
    assign sat_o        = sat_q;
    assign cnt_o        = cnt_q;
    assign busy_o       = (state_q == ST_ACCUM);
    assign done_o       = (state_q == ST_DONE);
    assign prod_ready_o = (state_q == ST_ACCUM) & ena;

endmodule

// File: tb/tb_booth_mac_accumulator.sv
// Directed self-checking bench for booth_mac_accumulator.
module tb_booth_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        start_i;
    logic [3:0]  len_i;
    logic [7:0]  prod_i;
    logic        prod_valid_i;
    logic        prod_ready_o;
    logic        res_ready_i;
    logic [10:0] acc_o;
    logic        done_o;
    logic        sat_o;
    logic        busy_o;
    logic [3:0]  cnt_o;

    int n_assert = 0;
    int n_fail   = 0;

    booth_mac_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .start_i      (start_i),
        .len_i        (len_i),
        .prod_i       (prod_i),
        .prod_valid_i (prod_valid_i),
        .prod_ready_o (prod_ready_o),
        .res_ready_i  (res_ready_i),
        .acc_o        (acc_o),
        .done_o       (done_o),
        .sat_o        (sat_o),
        .busy_o       (busy_o),
        .cnt_o        (cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_blk(input logic [3:0] len);
        start_i = 1'b1;
        len_i   = len;
        tick();
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] p);
        prod_i       = p;
        prod_valid_i = 1'b1;
        tick();
        prod_valid_i = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        ena          = 1'b1;
        start_i      = 1'b0;
        len_i        = 4'd0;
        prod_i       = 8'h00;
        prod_valid_i = 1'b0;
        res_ready_i  = 1'b0;
        tick();
        tick();
        chk("rst_acc",   32'(acc_o), 32'h0);
        chk("rst_done",  32'(done_o), 32'h0);
        chk("rst_busy",  32'(busy_o), 32'h0);
        chk("rst_ready", 32'(prod_ready_o), 32'h0);
        chk("rst_cnt",   32'(cnt_o), 32'h0);
        chk("rst_sat",   32'(sat_o), 32'h0);
        rst_n = 1'b1;
        tick();

        // reset in the middle of a block
        start_blk(4'd4);
        chk("mb_busy",  32'(busy_o), 32'h1);
        chk("mb_ready", 32'(prod_ready_o), 32'h1);
        send(8'h05);
        send(8'h05);
        chk("mb_acc", 32'(acc_o), 32'd10);
        chk("mb_cnt", 32'(cnt_o), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("mb_rst_acc",   32'(acc_o), 32'h0);
        chk("mb_rst_busy",  32'(busy_o), 32'h0);
        chk("mb_rst_ready", 32'(prod_ready_o), 32'h0);
        chk("mb_rst_done",  32'(done_o), 32'h0);
        chk("mb_rst_cnt",   32'(cnt_o), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("mb_idle_busy", 32'(busy_o), 32'h0);

        // basic block of three
        start_blk(4'd3);
        chk("b_acc0", 32'(acc_o), 32'h0);
        chk("b_cnt0", 32'(cnt_o), 32'h0);
        send(8'h06);
        chk("b_acc1", 32'(acc_o), 32'd6);
        send(8'hF4);
        chk("b_acc2", 32'(acc_o), 32'h7FA);
        chk("b_done2", 32'(done_o), 32'h0);
        send(8'h0F);
        chk("b_acc3",  32'(acc_o), 32'd9);
        chk("b_done3", 32'(done_o), 32'h1);
        chk("b_busy3", 32'(busy_o), 32'h0);
        chk("b_sat3",  32'(sat_o), 32'h0);
        chk("b_cnt3",  32'(cnt_o), 32'd3);
        send(8'h22);
        chk("b_done_ignore", 32'(acc_o), 32'd9);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("b_idle_done", 32'(done_o), 32'h0);
        chk("b_idle_acc",  32'(acc_o), 32'd9);

        // positive saturation
        start_blk(4'd9);
        for (int i = 0; i < 8; i++) send(8'h7F);
        chk("sp_acc8", 32'(acc_o), 32'd1016);
        chk("sp_sat8", 32'(sat_o), 32'h0);
        send(8'h7F);
        chk("sp_acc9",  32'(acc_o), 32'd1023);
        chk("sp_sat9",  32'(sat_o), 32'h1);
        chk("sp_done9", 32'(done_o), 32'h1);
        chk("sp_cnt9",  32'(cnt_o), 32'd9);

        // start and res_ready together in DONE restart straight into ACCUM
        start_i     = 1'b1;
        res_ready_i = 1'b1;
        len_i       = 4'd8;
        tick();
        start_i     = 1'b0;
        res_ready_i = 1'b0;
        chk("dc_busy", 32'(busy_o), 32'h1);
        chk("dc_acc",  32'(acc_o), 32'h0);
        chk("dc_sat",  32'(sat_o), 32'h0);
        for (int i = 0; i < 8; i++) send(8'h80);
        chk("mn_acc8",  32'(acc_o), 32'h400);
        chk("mn_sat8",  32'(sat_o), 32'h0);
        chk("mn_done8", 32'(done_o), 32'h1);

        // negative saturation
        start_blk(4'd9);
        for (int i = 0; i < 9; i++) send(8'h80);
        chk("sn_acc9",  32'(acc_o), 32'h400);
        chk("sn_sat9",  32'(sat_o), 32'h1);
        chk("sn_done9", 32'(done_o), 32'h1);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;

        // enable and handshake gaps
        start_blk(4'd2);
        ena          = 1'b0;
        prod_i       = 8'h03;
        prod_valid_i = 1'b1;
        #1;
        chk("en_ready0", 32'(prod_ready_o), 32'h0);
        tick();
        tick();
        chk("en_cnt_hold", 32'(cnt_o), 32'h0);
        chk("en_acc_hold", 32'(acc_o), 32'h0);
        chk("en_busy",     32'(busy_o), 32'h1);
        ena = 1'b1;
        tick();
        prod_valid_i = 1'b0;
        chk("en_acc1", 32'(acc_o), 32'd3);
        chk("en_cnt1", 32'(cnt_o), 32'd1);
        tick();
        tick();
        tick();
        chk("gap_cnt", 32'(cnt_o), 32'd1);
        start_i = 1'b1;
        len_i   = 4'd5;
        tick();
        start_i = 1'b0;
        chk("ign_start_cnt", 32'(cnt_o), 32'd1);
        chk("ign_start_acc", 32'(acc_o), 32'd3);
        chk("ign_start_busy", 32'(busy_o), 32'h1);
        send(8'h04);
        chk("en_acc2",  32'(acc_o), 32'd7);
        chk("en_done2", 32'(done_o), 32'h1);
        chk("en_cnt2",  32'(cnt_o), 32'd2);
        ena         = 1'b0;
        res_ready_i = 1'b1;
        tick();
        chk("en_done_hold", 32'(done_o), 32'h1);
        ena = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("en_done_rel", 32'(done_o), 32'h0);

        // len 0 means a full 16-product block
        start_blk(4'd0);
        for (int i = 0; i < 15; i++) send(8'h01);
        chk("l0_cnt15",  32'(cnt_o), 32'd15);
        chk("l0_done15", 32'(done_o), 32'h0);
        send(8'h01);
        chk("l0_acc16",  32'(acc_o), 32'd16);
        chk("l0_done16", 32'(done_o), 32'h1);
        chk("l0_cnt16",  32'(cnt_o), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
